region_fill_drawer: RTL
=======================

# region_fill_drawer

Parametrised raster filler that writes a rectangular region of the frame buffer over the shared VGA pixel bus, one pixel per clock. It supports solid, checkerboard and stripe patterns with programmable origin, size, colours and tile size. It drives the bus only while busy and tri-states it otherwise, so several drawers can share one bus. It generalises the full-screen refresh block, which was fixed at 256x256 with a fixed pattern.

## Interface
Parameters:
- X_W, 8, x coordinate width; frame width is 2^X_W
- Y_W, 8, y coordinate width
- RGB_W, 24, colour width

Ports:
- clk  in  1  single clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  request a fill; sampled only in IDLE
- abort  in  1  terminate the current fill; sampled only in DRAW
- stall  in  1  bus backpressure; holds the scan position
- x0  in  X_W  region origin x
- y0  in  Y_W  region origin y
- w  in  X_W+1  region width in pixels, 0..2^X_W
- h  in  Y_W+1  region height in pixels, 0..2^Y_W
- mode  in  2  0 solid, 1 checkerboard, 2 horizontal stripes, 3 vertical stripes
- tile_log2  in  3  tile/stripe size is 2^tile_log2 pixels
- color_a, color_b  in  RGB_W  pattern colours
- vga_x_out_bus  out(tri)  X_W  pixel x
- vga_y_out_bus  out(tri)  Y_W  pixel y
- vga_RGB_out_bus  out(tri)  RGB_W  pixel colour
- vga_draw_enable_bus  out(tri)  1  pixel write strobe
- busy  out  1  high in DRAW and DONE
- done  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, DRAW, DONE.
  - IDLE: if start=1, go to DRAW.
  - DRAW: go to DONE after the last pixel is issued, or when abort=1.
  - DONE: go to IDLE unconditionally.
- On leaving IDLE, all configuration inputs are latched. Input changes during a fill have no effect.
- If w=0 or h=0, the FSM goes IDLE→DONE directly. No pixels are written and done still pulses.
- Local scan counters cx (X_W+1 bits) and cy (Y_W+1 bits) start at 0 and advance in raster order, x fastest.
  - When cx reaches w-1, cx wraps to 0 and cy increments.
  - The last pixel is cx=w-1, cy=h-1.
- Screen coordinates are x=(x0+cx) mod 2^X_W and y=(y0+cy) mod 2^Y_W. Regions that extend past the frame edge wrap around.
- Pattern selection uses bit p, taken on local offsets:
  - mode 0: p=0
  - mode 1: p=bit0 of (cx>>tile_log2) XOR bit0 of (cy>>tile_log2)
  - mode 2: p=bit0 of (cy>>tile_log2)
  - mode 3: p=bit0 of (cx>>tile_log2)
  - colour is color_b if p=1, else color_a.
- Output registers:
  - In a DRAW cycle with stall=0 and abort=0, the current pixel is loaded into the x/y/RGB output registers, draw_enable_reg is set to 1, and the counters advance.
  - In every other cycle, draw_enable_reg is 0 and x/y/RGB hold their values.
- Stall in DRAW: the counters hold, no pixel is issued, and the state is unchanged.
- Abort in DRAW takes priority over stall and over pixel issue. The FSM goes to DONE and no further pixels are issued. Pixels already issued remain written.
- The bus is driven from the output registers while busy=1, and is high-Z in IDLE.
- There are no combinational paths from inputs to outputs.

## Timing
- Reset (resetn=0, asynchronous):
  - State is IDLE; cx=cy=0.
  - x/y/RGB registers are 0 and draw_enable_reg is 0.
  - busy=0, done=0, and all bus outputs are Z.
  - Reset asserted mid-fill aborts immediately with no done pulse.
- Start is sampled on rising edge E0. DRAW is entered from E0.
- With no stall, pixel k (k=0..N-1, N=w*h) is issued on edge E(k+1). It is visible on the bus with draw_enable=1 during the cycle after that edge.
- After the last pixel is issued, the state is DONE for one cycle:
  - The bus still shows the last pixel with draw_enable=1.
  - busy=1 and done=1.
  - The bus is Z from the next edge onward.
- Unstalled fill timing: done is high in cycle N+1 after E0, and the total busy time is N+1 cycles.
- Each stall cycle adds exactly one cycle to that timing.
- A start asserted while busy is ignored. A start held high in the DONE cycle is not accepted until IDLE, so a back-to-back fill begins one cycle after done.
- Full-frame fill: w=2^X_W, h=2^Y_W; the counters never overflow their X_W+1 / Y_W+1 widths.

## Test plan
- Solid fill, with X_W=Y_W=8, x0=10, y0=20, w=3, h=2, mode 0, color_a=FF0000:
  - exactly 6 strobes at (10,20),(11,20),(12,20),(10,21),(11,21),(12,21), all with RGB FF0000;
  - done is high 7 cycles after the start edge;
  - the bus is Z before and after the fill.
- Checkerboard, with w=h=4, tile_log2=1, color_a=000000, color_b=FFFFFF:
  - rows 0 and 1 read A,A,B,B;
  - rows 2 and 3 read B,B,A,A.
- Wrap and full frame:
  - x0=254, w=4 writes x=254,255,0,1;
  - w=256, h=256 gives 65536 strobes, done at cycle 65537, and no lockup.
- Stall and abort:
  - stall held for 3 cycles mid-fill gives no duplicated and no skipped pixels, and done is 3 cycles later than the unstalled case;
  - abort after the 5th pixel gives exactly 5 strobes, then a DONE cycle with a done pulse.
- Edge cases:
  - w=0 gives no strobes, a done pulse 1 cycle after start, and busy high for 1 cycle;
  - resetn pulsed low mid-fill immediately floats the bus, with no done pulse and the FSM in IDLE;
  - a new start after reset runs a normal fill.

Source files
------------

// File: rtl/region_fill_drawer.sv
// Rectangular region filler that writes solid, checkerboard or stripe patterns over a shared
// tri-state VGA pixel bus at one pixel per clock. It drives the bus only while busy.
module region_fill_drawer #(
    parameter int X_W   = 8,
    parameter int Y_W   = 8,
    parameter int RGB_W = 24
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             abort,
    input  logic             stall,
    input  logic [X_W-1:0]   x0,
    input  logic [Y_W-1:0]   y0,
    input  logic [X_W:0]     w,
    input  logic [Y_W:0]     h,
    input  logic [1:0]       mode,
    input  logic [2:0]       tile_log2,
    input  logic [RGB_W-1:0] color_a,
    input  logic [RGB_W-1:0] color_b,
    output wire  [X_W-1:0]   vga_x_out_bus,
    output wire  [Y_W-1:0]   vga_y_out_bus,
    output wire  [RGB_W-1:0] vga_RGB_out_bus,
    output wire              vga_draw_enable_bus,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAW,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [X_W-1:0]   x0;
        logic [Y_W-1:0]   y0;
        logic [X_W:0]     w;
        logic [Y_W:0]     h;
        logic [1:0]       mode;
        logic [2:0]       tile;
        logic [RGB_W-1:0] color_a;
        logic [RGB_W-1:0] color_b;
    } cfg_t;

    localparam logic [X_W:0] X_ONE = 1;
    localparam logic [Y_W:0] Y_ONE = 1;

    state_t           state_q, state_d;
    cfg_t             cfg_q, cfg_d;
    logic [X_W:0]     cx_q, cx_d;
    logic [Y_W:0]     cy_q, cy_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             de_q, de_d;

    logic [X_W-1:0]   pix_x;
    logic [Y_W-1:0]   pix_y;
    logic [RGB_W-1:0] pix_rgb;
    logic [X_W:0]     tx;
    logic [Y_W:0]     ty;
    logic             bit_x, bit_y, pat;
    logic             last_col, last_row;

    // Screen position wraps naturally by truncating the sum to the frame width.
    assign pix_x    = cfg_q.x0 + cx_q[X_W-1:0];
    assign pix_y    = cfg_q.y0 + cy_q[Y_W-1:0];
    assign tx       = cx_q >> cfg_q.tile;
    assign ty       = cy_q >> cfg_q.tile;
    assign bit_x    = |(tx & X_ONE);
    assign bit_y    = |(ty & Y_ONE);
    assign last_col = (cx_q == cfg_q.w - 1'b1);
    assign last_row = (cy_q == cfg_q.h - 1'b1);

    always_comb begin
        pat = 1'b0;
        case (cfg_q.mode)
            2'd1:    pat = bit_x ^ bit_y;
            2'd2:    pat = bit_y;
            2'd3:    pat = bit_x;
            default: pat = 1'b0;
        endcase
        pix_rgb = pat ? cfg_q.color_b : cfg_q.color_a;
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        cfg_d   = cfg_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        x_d     = x_q;
        y_d     = y_q;
        rgb_d   = rgb_q;
        de_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cfg_d   = '{x0: x0, y0: y0, w: w, h: h, mode: mode, tile: tile_log2,
                                color_a: color_a, color_b: color_b};
                    cx_d    = '0;
                    cy_d    = '0;
                    state_d = (w == '0 || h == '0) ? S_DONE : S_DRAW;
                end
            end
            S_DRAW: begin
                // Abort wins over both stall and pixel issue.
                if (abort) begin
                    state_d = S_DONE;
                end else if (!stall) begin
                    x_d   = pix_x;
                    y_d   = pix_y;
                    rgb_d = pix_rgb;
                    de_d  = 1'b1;
                    if (last_col) begin
                        cx_d = '0;
                        if (last_row) begin
                            cy_d    = '0;
                            state_d = S_DONE;
                        end else begin
                            cy_d = cy_q + 1'b1;
                        end
                    end else begin
                        cx_d = cx_q + 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cfg_q   <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            rgb_q   <= '0;
            de_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            cfg_q   <= cfg_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            x_q     <= x_d;
            y_q     <= y_d;
            rgb_q   <= rgb_d;
            de_q    <= de_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);

    assign vga_x_out_bus       = busy ? x_q   : {X_W{1'bz}};
    assign vga_y_out_bus       = busy ? y_q   : {Y_W{1'bz}};
    assign vga_RGB_out_bus     = busy ? rgb_q : {RGB_W{1'bz}};
    assign vga_draw_enable_bus = busy ? de_q  : 1'bz;

endmodule
